aes_decrypt_top: RTL and testbench
==================================

# aes_decrypt_top

Iterative AES-128 inverse-cipher core. Takes a 128-bit ciphertext and the final (round-10) round key, and reconstructs round keys 9..0 on the fly by inverse key expansion. Produces the plaintext after one round per clock, with a level-style ready flag. It sits behind the key-schedule/host logic that already holds round key 10.

## Interface
- No parameters (fixed AES-128, Nr = 10).
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cipher_text  in  128  ciphertext block; bits [127:120] = byte 0 (column-major, FIPS-197 order).
- round_key_10  in  128  last round key of the expanded schedule, same byte order.
- decipher_new_en  in  1  start strobe; sampled on a rising edge.
- en  in  1  active-high stall; freezes round progression while high.
- decipher_ready  out  1  high when plain_text holds a completed result.
- plain_text  out  128  decrypted block, same byte order.

## Operation
- Idle until decipher_new_en = 1 at an edge (E0). E0 is accepted regardless of `en` and regardless of busy, so a start while busy aborts and restarts. At E0:
  - state <= cipher_text ^ round_key_10
  - key <= round_key_10
  - round <= 9
  - busy <= 1
  - decipher_ready <= 0
- Each active round cycle (busy, en = 0):
  - Derive the previous key from key words w0..w3 (w0 = bits 127:96), using i = round + 1:
    - w3' = w3^w2
    - w2' = w2^w1
    - w1' = w1^w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(i)
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte. SubWord uses the forward S-box.
  - Rounds 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key'). Then key <= key', round <= round-1.
  - Round 0: plain_text <= InvSubBytes(InvShiftRows(state)) ^ key', with no InvMixColumns. Then decipher_ready <= 1 and busy <= 0.
- InvMixColumns uses GF(2^8) multiply by 0e,0b,0d,09, with reduction polynomial 0x11b.
- `en` = 1 while busy holds state, key and round unchanged. While idle it has no effect.
- plain_text holds the last result until the next completion. It is not cleared by a new start.

## Timing
- Reset values: decipher_ready = 0, plain_text = 0, busy = 0, state/key/round = 0.
- Latency, with no stall: start sampled at E0; rounds at E1..E10; plain_text valid and decipher_ready = 1 after E10 (10 cycles after E0).
- Each stalled cycle adds one cycle of latency.
- decipher_ready falls at the edge that accepts the next start. Otherwise it stays high indefinitely.
- decipher_new_en held high for several cycles restarts each cycle. Completion then requires 10 cycles after the last high sample.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values.
- cipher_text and round_key_10 are sampled only at E0 and may change afterwards.

## Structure
- Shared package `aes_pkg`:
  - forward and inverse S-box functions
  - Rcon function
  - xtime and GF multiply functions (x9, x11, x13, x14)
  - InvShiftRows, InvSubBytes and InvMixColumns functions on 128-bit state
- One natural sub-module: `aes_inv_key_step`. It is combinational: (key_i, i) -> key_{i-1}.
- Top module holds the state, key, round counter, busy, ready and output registers.

## Test plan
- FIPS-197 C.1:
  - Stimulus: cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, round_key_10 13111d7fe3944a17f307a78b4d2b30c5, one-cycle start, en = 0.
  - Response: after 10 cycles, plain_text = 00112233445566778899aabbccddeeff and decipher_ready = 1. decipher_ready = 0 during E1..E9.
- FIPS-197 App. B:
  - Stimulus: cipher_text 3925841d02dc09fbdc118597196a0b32, round_key_10 d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Response: plain_text = 3243f6a8885a308d313198a2e0370734.
- Back-to-back jobs:
  - Stimulus: second start 2 cycles after the first result, with cipher_text daba0685a6b6ef1d096f7980accf3ac5 and round_key_10 0000fd92814d079f28dad0babe23ef7f (zero-extended).
  - Response: ready drops at E0, rises 10 cycles later, and plain_text matches the software model. The first result stays on plain_text until then.
- Stall:
  - Stimulus: C.1 vector with en = 1 for 3 cycles mid-run.
  - Response: ready after 13 cycles, same plaintext as the unstalled run.
- Restart and reset:
  - Stimulus: start a new C.1 job 4 cycles into an App. B job.
  - Response: C.1 plaintext 10 cycles after the restart.
  - Stimulus: reset_n pulsed low mid-run.
  - Response: ready = 0, plain_text = 0 asynchronously, and no completion follows.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box tables and the inverse round transforms
// used by the iterative decryption core.
package aes_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } dec_state_t;

    localparam logic [3:0] FIRST_ROUND = 4'd9;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Round constant for key word index 4*i; i outside 1..10 never occurs.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Byte n of the block sits at [127-8n -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = inv_sbox(s[8*n +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
            o[119-32*c -: 8] = gmul9(a0) ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
            o[111-32*c -: 8] = gmul13(a0) ^ gmul9(a1) ^ gmul14(a2) ^ gmul11(a3);
            o[103-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2) ^ gmul14(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// Combinational inverse key expansion: round key i in, round key i-1 out.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_cur,
    input  logic [3:0]   rcon_idx,
    output logic [127:0] key_prev
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w1_prev, w2_prev, w3_prev;
    logic [31:0] rot_word;
    logic [31:0] sub_word;

    assign w0 = key_cur[127:96];
    assign w1 = key_cur[95:64];
    assign w2 = key_cur[63:32];
    assign w3 = key_cur[31:0];

    assign w3_prev = w3 ^ w2;
    assign w2_prev = w2 ^ w1;
    assign w1_prev = w1 ^ w0;

    // The recovered w3 feeds the schedule core exactly as in forward expansion.
    assign rot_word = {w3_prev[23:0], w3_prev[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
        end
    endgenerate

    assign key_prev = {w0 ^ sub_word ^ {rcon(rcon_idx), 24'h000000},
                       w1_prev, w2_prev, w3_prev};

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys
// regenerated backwards from round key 10.
module aes_decrypt_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] cipher_text,
    input  logic [127:0] round_key_10,
    input  logic         decipher_new_en,
    input  logic         en,
    output logic         decipher_ready,
    output logic [127:0] plain_text
);

    dec_state_t   fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   round_reg, round_next;
    logic         ready_reg, ready_next;
    logic [127:0] plain_reg, plain_next;

    logic [127:0] key_prev;
    logic [127:0] round_core;

    aes_inv_key_step u_key_step (
        .key_cur  (key_reg),
        .rcon_idx (round_reg + 4'd1),
        .key_prev (key_prev)
    );

    // Shared by every round; the last round simply skips InvMixColumns.
    assign round_core = inv_sub_bytes(inv_shift_rows(state_reg)) ^ key_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg   <= ST_IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            round_reg <= '0;
            ready_reg <= 1'b0;
            plain_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            key_reg   <= key_next;
            round_reg <= round_next;
            ready_reg <= ready_next;
            plain_reg <= plain_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        key_next   = key_reg;
        round_next = round_reg;
        ready_next = ready_reg;
        plain_next = plain_reg;

        // A start wins over everything, including a stall or a job in flight.
        if (decipher_new_en) begin
            fsm_next   = ST_RUN;
            state_next = cipher_text ^ round_key_10;
            key_next   = round_key_10;
            round_next = FIRST_ROUND;
            ready_next = 1'b0;
        end else if (fsm_reg == ST_RUN && !en) begin
            key_next = key_prev;
            if (round_reg == 4'd0) begin
                plain_next = round_core;
                ready_next = 1'b1;
                fsm_next   = ST_IDLE;
            end else begin
                state_next = inv_mix_columns(round_core);
                round_next = round_reg - 4'd1;
            end
        end
    end

    assign decipher_ready = ready_reg;
    assign plain_text     = plain_reg;

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Directed bench for aes_decrypt_top: FIPS-197 vectors, back-to-back jobs,
// stall, restart and asynchronous reset.
module tb_aes_decrypt_top;

    logic         clk;
    logic         reset_n;
    logic [127:0] cipher_text;
    logic [127:0] round_key_10;
    logic         decipher_new_en;
    logic         en;
    logic         decipher_ready;
    logic [127:0] plain_text;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] X_CT   = 128'hdaba0685a6b6ef1d096f7980accf3ac5;
    localparam logic [127:0] X_RK   = 128'h0000fd92814d079f28dad0babe23ef7f;

    aes_decrypt_top dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cipher_text     (cipher_text),
        .round_key_10    (round_key_10),
        .decipher_new_en (decipher_new_en),
        .en              (en),
        .decipher_ready  (decipher_ready),
        .plain_text      (plain_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference forward cipher, with its S-box derived from GF(2^8) inverses.
    logic [7:0]   sb_tab [256];
    logic [127:0] rk_m [11];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r1 = rotl8(inv); r2 = rotl8(r1); r3 = rotl8(r2); r4 = rotl8(r3);
            sb_tab[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    // Recover the whole schedule from the last round key via w[k-4] = w[k] ^ T(w[k-1]).
    task automatic expand_from_last(input logic [127:0] rk10);
        logic [31:0] w [44];
        logic [7:0]  rc [11];
        logic [31:0] t;
        rc[0] = 8'h00; rc[1] = 8'h01;
        for (int n = 2; n <= 10; n++) rc[n] = gf_mul(rc[n-1], 8'h02);
        w[40] = rk10[127:96]; w[41] = rk10[95:64]; w[42] = rk10[63:32]; w[43] = rk10[31:0];
        for (int j = 39; j >= 0; j--) begin
            t = w[j+3];
            if ((j + 4) % 4 == 0) t = sub_word_m({t[23:0], t[31:24]}) ^ {rc[(j+4)/4], 24'h0};
            w[j] = w[j+4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt_m(input logic [127:0] pt);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [127:0] s;
        s = pt ^ rk_m[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) a[k] = sb_tab[s[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a[4*c]   = gf_mul(t[4*c], 8'h02) ^ gf_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    a[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 8'h02) ^ gf_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    a[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 8'h02) ^ gf_mul(t[4*c+3], 8'h03);
                    a[4*c+3] = gf_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 8'h02);
                end
            end else begin
                for (int k = 0; k < 16; k++) a[k] = t[k];
            end
            for (int k = 0; k < 16; k++) s[127-8*k -: 8] = a[k];
            s = s ^ rk_m[rnd];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [127:0] ct, input logic [127:0] rk);
        cipher_text     = ct;
        round_key_10    = rk;
        decipher_new_en = 1'b1;
        tick();
        decipher_new_en = 1'b0;
        cipher_text     = ~ct;
        round_key_10    = ~rk;
    endtask

    initial begin
        build_sbox();
        reset_n = 1'b0; cipher_text = '0; round_key_10 = '0;
        decipher_new_en = 1'b0; en = 1'b0;
        tick(); tick();
        chk1("reset_ready", decipher_ready, 1'b0);
        chk128("reset_plain", plain_text, 128'h0);
        reset_n = 1'b1;
        tick();
        $display("reset: ready=%b plain=%h", decipher_ready, plain_text);

        // FIPS-197 C.1, unstalled.
        start_job(C1_CT, C1_RK);
        chk1("c1_ready_e0", decipher_ready, 1'b0);
        for (int n = 1; n <= 9; n++) begin
            tick();
            chk1("c1_ready_busy", decipher_ready, 1'b0);
        end
        tick();
        chk1("c1_ready_done", decipher_ready, 1'b1);
        chk128("c1_plain", plain_text, C1_PT);
        $display("c1: ready=%b plain=%h", decipher_ready, plain_text);

        // FIPS-197 App. B; previous result held until completion.
        tick();
        chk128("c1_plain_hold", plain_text, C1_PT);
        start_job(B_CT, B_RK);
        chk128("b_plain_old", plain_text, C1_PT);
        for (int n = 1; n <= 9; n++) tick();
        chk1("b_ready_e9", decipher_ready, 1'b0);
        tick();
        chk1("b_ready_done", decipher_ready, 1'b1);
        chk128("b_plain", plain_text, B_PT);
        $display("appb: ready=%b plain=%h", decipher_ready, plain_text);

        // Back-to-back: next start two cycles after the result.
        tick(); tick();
        chk1("b2b_ready_hold", decipher_ready, 1'b1);
        start_job(X_CT, X_RK);
        chk1("b2b_ready_drop", decipher_ready, 1'b0);
        for (int n = 1; n <= 9; n++) tick();
        chk128("b2b_plain_old", plain_text, B_PT);
        chk1("b2b_ready_e9", decipher_ready, 1'b0);
        tick();
        chk1("b2b_ready_done", decipher_ready, 1'b1);
        expand_from_last(X_RK);
        chk128("b2b_roundtrip", encrypt_m(plain_text), X_CT);
        $display("b2b: ready=%b plain=%h", decipher_ready, plain_text);

        // Stall for three cycles in the middle of a C.1 job.
        start_job(C1_CT, C1_RK);
        for (int n = 1; n <= 4; n++) tick();
        en = 1'b1;
        for (int n = 1; n <= 3; n++) tick();
        en = 1'b0;
        for (int n = 1; n <= 5; n++) tick();
        chk1("stall_ready_e12", decipher_ready, 1'b0);
        tick();
        chk1("stall_ready_e13", decipher_ready, 1'b1);
        chk128("stall_plain", plain_text, C1_PT);
        $display("stall: ready=%b plain=%h", decipher_ready, plain_text);

        // Restart: App. B job aborted 4 cycles in by a C.1 start.
        start_job(B_CT, B_RK);
        for (int n = 1; n <= 3; n++) tick();
        start_job(C1_CT, C1_RK);
        for (int n = 1; n <= 9; n++) begin
            tick();
            chk1("restart_ready_busy", decipher_ready, 1'b0);
        end
        tick();
        chk1("restart_ready_done", decipher_ready, 1'b1);
        chk128("restart_plain", plain_text, C1_PT);
        $display("restart: ready=%b plain=%h", decipher_ready, plain_text);

        // Asynchronous reset mid-run.
        start_job(B_CT, B_RK);
        for (int n = 1; n <= 3; n++) tick();
        reset_n = 1'b0;
        #2;
        chk1("areset_ready", decipher_ready, 1'b0);
        chk128("areset_plain", plain_text, 128'h0);
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) tick();
        chk1("areset_no_done", decipher_ready, 1'b0);
        chk128("areset_plain_after", plain_text, 128'h0);
        $display("reset_mid: ready=%b plain=%h", decipher_ready, plain_text);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
